// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-bus responder.
//   state_t : responder FSM states
//   LEN_W   : width of the burst-length field (extra read beats)
//   ADDR_W / DATA_W : default bus widths used by the interface and the top
package cpu_mem_pkg;

    localparam int LEN_W  = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/memory_bus_responder_if.sv
// Request/response bus between the CPU-side initiator and the memory responder.
//   req_valid/req_ready : request handshake; req_write, req_addr, req_wdata, req_len
//   rsp_valid/rsp_ready : response-beat handshake; rsp_rdata, rsp_err
// Modports: master = initiator (CPU side), slave = responder.
interface memory_bus_responder_if #(
    parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W = cpu_mem_pkg::DATA_W
);
    import cpu_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [LEN_W-1:0]  req_len;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/ram_sync_array.sv
// Single-port synchronous RAM: one write port, registered read.
//   clk   : clock
//   we    : write enable (mem[addr] <= wdata)
//   re    : read enable (rdata <= mem[addr] on the same edge)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, holds its value while re is low
module ram_sync_array #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage and read register have no reset so they map onto RAM macros;
    // contents survive a reset of the surrounding logic.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/memory_bus_responder.sv
// Target-side memory responder for the CPU bus.
// Accepts single reads/writes and incrementing read bursts, inserts WAIT_STATES
// idle cycles before every RAM access and returns one response beat per access.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : request/response bus (slave side)
//   busy  : high whenever the FSM is not in IDLE
module memory_bus_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W      = cpu_mem_pkg::DATA_W,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    memory_bus_responder_if.slave   bus,
    output logic                    busy
);

    localparam int         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [7:0] WAIT_LAST = 8'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
    // State entered after accept or after a burst beat handshake.
    localparam state_t     PRE_STATE = (WAIT_STATES == 0) ? ACCESS : WAIT;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic [LEN_W-1:0]  beats_left;
    logic [7:0]        wait_cnt;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              err_q;
    logic              busy_q;

    logic              in_range;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    assign in_range = 32'(addr_q) < MEM_DEPTH;
    // Out-of-range beats never touch the RAM.
    assign ram_we   = (state == ACCESS) &&  write_q && in_range;
    assign ram_re   = (state == ACCESS) && !write_q && in_range;

    ram_sync_array #(
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (IDX_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q[IDX_W-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            beats_left  <= '0;
            wait_cnt    <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        write_q     <= bus.req_write;
                        beats_left  <= bus.req_write ? '0 : bus.req_len;
                        wait_cnt    <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= PRE_STATE;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        state    <= ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ACCESS: begin
                    err_q       <= !in_range;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        // An error beat ends the burst; remaining beats are dropped.
                        if (beats_left != '0 && !err_q) begin
                            addr_q     <= addr_q + ADDR_W'(1);
                            beats_left <= beats_left - LEN_W'(1);
                            state      <= PRE_STATE;
                        end else begin
                            req_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = err_q;
    // The RAM read register only loads in ACCESS, so it is stable throughout RESP.
    assign bus.rsp_rdata = (!rsp_valid_q || err_q) ? '0 : (write_q ? wdata_q : ram_rdata);
    assign busy          = busy_q;

endmodule

// File: tb/tb_memory_bus_responder.sv
// Self-checking bench for memory_bus_responder. Three instances share one stimulus
// path selected by sel: 0 = defaults, 1 = MEM_DEPTH 128, 2 = WAIT_STATES 0.
module tb_memory_bus_responder;

    localparam int DEPTH_OF [3] = '{256, 128, 256};
    localparam int WS_OF    [3] = '{1, 1, 0};

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_write, rsp_ready;
    logic [7:0] req_addr, req_wdata;
    logic [3:0] req_len;
    int         sel;

    logic       busy_a, busy_b, busy_c;
    logic       o_req_ready, o_rsp_valid, o_rsp_err, o_busy;
    logic [7:0] o_rsp_rdata;

    logic [7:0] model_mem [3][256];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    memory_bus_responder_if bus_a ();
    memory_bus_responder_if bus_b ();
    memory_bus_responder_if bus_c ();

    assign bus_a.req_valid = req_valid && (sel == 0);
    assign bus_b.req_valid = req_valid && (sel == 1);
    assign bus_c.req_valid = req_valid && (sel == 2);
    assign bus_a.rsp_ready = rsp_ready && (sel == 0);
    assign bus_b.rsp_ready = rsp_ready && (sel == 1);
    assign bus_c.rsp_ready = rsp_ready && (sel == 2);
    assign bus_a.req_write = req_write;
    assign bus_b.req_write = req_write;
    assign bus_c.req_write = req_write;
    assign bus_a.req_addr  = req_addr;
    assign bus_b.req_addr  = req_addr;
    assign bus_c.req_addr  = req_addr;
    assign bus_a.req_wdata = req_wdata;
    assign bus_b.req_wdata = req_wdata;
    assign bus_c.req_wdata = req_wdata;
    assign bus_a.req_len   = req_len;
    assign bus_b.req_len   = req_len;
    assign bus_c.req_len   = req_len;

    memory_bus_responder #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(256), .WAIT_STATES(1))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a), .busy(busy_a));
    memory_bus_responder #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(128), .WAIT_STATES(1))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b), .busy(busy_b));
    memory_bus_responder #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(256), .WAIT_STATES(0))
        dut_c (.clk(clk), .reset(reset), .bus(bus_c), .busy(busy_c));

    always_comb begin
        o_req_ready = bus_a.req_ready;
        o_rsp_valid = bus_a.rsp_valid;
        o_rsp_rdata = bus_a.rsp_rdata;
        o_rsp_err   = bus_a.rsp_err;
        o_busy      = busy_a;
        case (sel)
            1: begin
                o_req_ready = bus_b.req_ready;
                o_rsp_valid = bus_b.rsp_valid;
                o_rsp_rdata = bus_b.rsp_rdata;
                o_rsp_err   = bus_b.rsp_err;
                o_busy      = busy_b;
            end
            2: begin
                o_req_ready = bus_c.req_ready;
                o_rsp_valid = bus_c.rsp_valid;
                o_rsp_rdata = bus_c.rsp_rdata;
                o_rsp_err   = bus_c.rsp_err;
                o_busy      = busy_c;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (sel=%0d): got 0x%0h expected 0x%0h", tag, sel, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " req_ready"}, 32'(o_req_ready), 1);
        check({tag, " rsp_valid"}, 32'(o_rsp_valid), 0);
        check({tag, " busy"},      32'(o_busy), 0);
    endtask

    // Present one request and complete its handshake; returns 0 if req_ready never came.
    task automatic accept(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [3:0] len, output bit ok);
        int n = 0;
        while (!o_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = o_req_ready;
        if (!ok) begin
            check("req_ready timeout", 0, 1);
            return;
        end
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_len   = len;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        // Request fields after accept must not matter.
        req_write = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
        req_len   = 4'($urandom);
    endtask

    // Full transaction checked against the reference model.
    // hold < 0: random rsp_ready back-pressure of 0..3 cycles per beat.
    task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [3:0] len, input int hold);
        int         ws    = WS_OF[sel];
        int         depth = DEPTH_OF[sel];
        int         beats = wr ? 1 : int'(len) + 1;
        logic [7:0] cur   = addr;
        bit         ok;
        accept(wr, addr, wdata, len, ok);
        if (!ok) return;
        for (int b = 0; b < beats; b++) begin
            // Edges are counted from the accept/handshake edge, which is edge 1.
            int         n = 1;
            int         h;
            int         bad = 0;
            bit         exp_err;
            logic [7:0] exp_data, d0;
            logic       e0;
            while (!o_rsp_valid && n < 60) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("latency beat%0d", b), n, ws + 2);
            if (!o_rsp_valid) return;
            exp_err  = int'(cur) >= depth;
            exp_data = exp_err ? 8'h00 : (wr ? wdata : model_mem[sel][cur]);
            check($sformatf("rdata @%02h", cur), 32'(o_rsp_rdata), 32'(exp_data));
            check($sformatf("err @%02h", cur),   32'(o_rsp_err),   32'(exp_err));
            check("req_ready low in RESP", 32'(o_req_ready), 0);
            check("busy in RESP", 32'(o_busy), 1);
            if (wr && !exp_err) model_mem[sel][cur] = wdata;
            h  = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
            d0 = o_rsp_rdata;
            e0 = o_rsp_err;
            for (int k = 0; k < h; k++) begin
                @(negedge clk);
                if (!o_rsp_valid || o_rsp_rdata !== d0 || o_rsp_err !== e0 || o_req_ready)
                    bad++;
            end
            if (h > 0) check($sformatf("stable under backpressure %0d", h), bad, 0);
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            if (exp_err) break;
            cur = cur + 8'd1;
        end
        check_idle("after txn");
    endtask

    initial begin
        bit ok;
        int n;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_len   = '0;
        rsp_ready = 1'b0;
        sel       = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_idle("reset");
            check("reset rsp_rdata", 32'(o_rsp_rdata), 0);
            check("reset rsp_err",   32'(o_rsp_err), 0);
        end

        // Preload every implemented word of each instance.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int a = 0; a < DEPTH_OF[s]; a++)
                run_txn(1'b1, 8'(a), 8'($urandom), 4'($urandom), 0);
        end

        // Write 0x3C @0x10 then read it back.
        sel = 0;
        run_txn(1'b1, 8'h10, 8'h3C, 4'd0, 0);
        run_txn(1'b0, 8'h10, 8'h00, 4'd0, 0);

        // Incrementing burst wrapping 0xFF -> 0x00.
        run_txn(1'b1, 8'hFE, 8'hA1, 4'd0, 0);
        run_txn(1'b1, 8'hFF, 8'hB2, 4'd0, 0);
        run_txn(1'b1, 8'h00, 8'hC3, 4'd0, 0);
        run_txn(1'b0, 8'hFE, 8'h00, 4'd2, 0);

        // Back-pressure of 5 cycles on every beat.
        run_txn(1'b0, 8'h40, 8'h00, 4'd3, 5);

        // Reset in the middle of a burst.
        accept(1'b0, 8'h30, 8'h00, 4'd7, ok);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("busy during reset", 32'(o_busy), 0);
        reset = 1'b1;
        @(negedge clk);
        check_idle("after mid-burst reset");

        // Write aborted by reset before its RAM access must leave memory unchanged.
        accept(1'b1, 8'h20, ~model_mem[0][8'h20], 4'd0, ok);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle("after aborted write");
        run_txn(1'b0, 8'h20, 8'h00, 4'd0, 0);

        // MEM_DEPTH 128: burst runs into the out-of-range region and stops.
        sel = 1;
        run_txn(1'b1, 8'h7F, 8'h5A, 4'd0, 0);
        run_txn(1'b0, 8'h7F, 8'h00, 4'd3, 0);
        run_txn(1'b1, 8'h90, 8'h77, 4'd0, 0);

        // WAIT_STATES 0: single read, and a write whose len is ignored.
        sel = 2;
        run_txn(1'b0, 8'h33, 8'h00, 4'd0, 0);
        run_txn(1'b1, 8'h34, 8'h9E, 4'd5, 0);
        run_txn(1'b0, 8'h34, 8'h00, 4'd1, 0);

        // Randomized traffic on every instance.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int t = 0; t < 40; t++) begin
                logic wr = ($urandom_range(0, 9) < 4);
                run_txn(wr, 8'($urandom), 8'($urandom), 4'($urandom), -1);
            end
        end

        // Make sure no instance is stuck busy at the end.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            n = 0;
            while (!o_req_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("final idle", 32'(o_req_ready), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
